// File: rtl/cdr_prbs_checker.sv
// PRBS-7 (x^7+x^6+1) checker: self-synchronises to the recovered CDR bit stream,
// declares lock, then counts bit errors. Define CDR_PRBS_BITCNT_EN to add the bit_cnt output.
module cdr_prbs_checker #(
    parameter int LOCK_CNT = 16,
    parameter int ERR_WIN  = 64,
    parameter int ERR_THR  = 8,
    parameter int ECW      = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           bit_in,
    input  logic           bit_valid,
    input  logic           clr_cnt,
    output logic           locked,
    output logic [1:0]     state,
    output logic           err_pulse,
    output logic [ECW-1:0] err_cnt
`ifdef CDR_PRBS_BITCNT_EN
    ,
    output logic [31:0]    bit_cnt
`endif
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = (ERR_WIN > 2) ? $clog2(ERR_WIN) : 1;
    localparam int EW = $clog2(ERR_THR + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      sr_q, sr_d;
    logic [2:0]      fill_q, fill_d;
    logic [MW-1:0]   match_q, match_d;
    logic [WW-1:0]   win_q, win_d;
    logic [EW-1:0]   werr_q, werr_d;
    logic            bit_err;

    logic            pred;
    logic            mismatch;
    logic [6:0]      sr_shift;
    logic [6:0]      sr_pred;
    logic            win_wrap;
    logic [EW-1:0]   werr_inc;

    // Once locked the local generator free-runs on its own prediction, so a
    // corrupted input bit never propagates into later predictions.
    assign pred     = sr_q[6] ^ sr_q[5];
    assign mismatch = bit_in ^ pred;
    assign sr_shift = {sr_q[5:0], bit_in};
    assign sr_pred  = {sr_q[5:0], pred};
    assign win_wrap = (win_q == WW'(ERR_WIN - 1));
    // An error on the wrapping bit belongs to the new window.
    assign werr_inc = (win_wrap ? '0 : werr_q) + EW'(1);

    // NOTE: every signal driven here gets its default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        bit_err = 1'b0;

        if (bit_valid) begin
            case (state_q)
                SEARCH: begin
                    sr_d = sr_shift;
                    if (fill_q == 3'd6) begin
                        fill_d = '0;
                        // All-zero is the PRBS lock-up state: refill instead.
                        if (sr_shift != '0) begin
                            state_d = VERIFY;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end

                VERIFY: begin
                    sr_d = sr_pred;
                    if (mismatch) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        match_d = match_q + MW'(1);
                        if (match_q == MW'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            win_d   = '0;
                            werr_d  = '0;
                        end
                    end
                end

                LOCKED: begin
                    sr_d  = sr_pred;
                    win_d = win_wrap ? '0 : win_q + WW'(1);
                    if (mismatch) begin
                        bit_err = 1'b1;
                        werr_d  = werr_inc;
                        if (werr_inc == EW'(ERR_THR)) begin
                            state_d = SEARCH;
                            fill_d  = '0;
                            match_d = '0;
                        end
                    end else if (win_wrap) begin
                        werr_d = '0;
                    end
                end

                default: begin
                    state_d = SEARCH;
                    fill_d  = '0;
                    match_d = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            sr_q      <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            win_q     <= '0;
            werr_q    <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_q     <= win_d;
            werr_q    <= werr_d;
            locked    <= (state_d == LOCKED);
            err_pulse <= bit_err;
        end
    end

    // A clear on the same edge as an error wins; the pulse is unaffected.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            err_cnt <= '0;
        end else if (bit_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ECW'(1);
        end
    end

`ifdef CDR_PRBS_BITCNT_EN
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            bit_cnt <= '0;
        end else if (bit_valid && (state_q == LOCKED) && (bit_cnt != '1)) begin
            bit_cnt <= bit_cnt + 32'd1;
        end
    end
`endif

    assign state = state_q;

endmodule

// File: tb/tb_cdr_prbs_checker.sv
// Self-checking bench for cdr_prbs_checker: a sequence-table reference model
// (PRBS-7 phase tracking) compared against the DUT every cycle, plus directed literal checks.
module tb_cdr_prbs_checker;

    localparam int LOCK_CNT = 16;
    localparam int ERR_WIN  = 64;
    localparam int ERR_THR  = 8;
    localparam int ECW      = 4;
    localparam int ERR_MAX  = (1 << ECW) - 1;
    localparam longint BC_MAX = 64'h0000_0000_FFFF_FFFF;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           bit_in = 1'b0;
    logic           bit_valid = 1'b0;
    logic           clr_cnt = 1'b0;
    logic           locked;
    logic [1:0]     state;
    logic           err_pulse;
    logic [ECW-1:0] err_cnt;
`ifdef CDR_PRBS_BITCNT_EN
    logic [31:0]    bit_cnt;
`endif

    always #5 clk = ~clk;

    cdr_prbs_checker #(
        .LOCK_CNT(LOCK_CNT),
        .ERR_WIN (ERR_WIN),
        .ERR_THR (ERR_THR),
        .ECW     (ECW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .clr_cnt  (clr_cnt),
        .locked   (locked),
        .state    (state),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt)
`ifdef CDR_PRBS_BITCNT_EN
        ,
        .bit_cnt  (bit_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One full period of the PRBS-7 sequence, b[n] = b[n-7] ^ b[n-6].
    bit seq [0:126];
    int tx_ph = 0;

    function automatic void build_seq();
        for (int n = 0; n < 7; n++) seq[n] = 1'b1;
        for (int n = 7; n < 127; n++) seq[n] = seq[n-7] ^ seq[n-6];
    endfunction

    function automatic bit tx_next();
        bit b;
        b = seq[tx_ph];
        tx_ph = (tx_ph + 1) % 127;
        return b;
    endfunction

    // Reference model: tracks the phase of the received stream within the sequence table.
    int     m_state = 0;
    int     m_phase = 0;
    int     m_match = 0;
    int     m_win   = 0;
    int     m_werr  = 0;
    int     m_err   = 0;
    bit     m_pulse = 1'b0;
    longint m_bc    = 0;
    bit     m_fill[$];

    function automatic int find_phase();
        for (int k = 0; k < 127; k++) begin
            bit ok;
            ok = 1'b1;
            for (int i = 0; i < 7; i++)
                if (seq[(k + 121 + i) % 127] != m_fill[i]) ok = 1'b0;
            if (ok) return k;
        end
        return 0;
    endfunction

    task automatic model_step();
        bit err;
        bit lock_bit;
        bit wrap;
        int ones;
        err = 1'b0;
        lock_bit = 1'b0;
        if (rst) begin
            m_state = 0; m_match = 0; m_win = 0; m_werr = 0;
            m_err = 0; m_pulse = 1'b0; m_bc = 0;
            m_fill.delete();
            return;
        end
        if (bit_valid) begin
            case (m_state)
                0: begin
                    m_fill.push_back(bit_in);
                    if (m_fill.size() == 7) begin
                        ones = 0;
                        foreach (m_fill[i]) ones += int'(m_fill[i]);
                        if (ones != 0) begin
                            m_phase = find_phase();
                            m_state = 1;
                            m_match = 0;
                        end
                        m_fill.delete();
                    end
                end
                1: begin
                    m_phase = (m_phase + 1) % 127;
                    if (bit_in == seq[m_phase]) begin
                        m_match++;
                        if (m_match == LOCK_CNT) begin
                            m_state = 2; m_win = 0; m_werr = 0;
                        end
                    end else begin
                        m_state = 0; m_match = 0; m_fill.delete();
                    end
                end
                default: begin
                    lock_bit = 1'b1;
                    m_phase = (m_phase + 1) % 127;
                    err = (bit_in != seq[m_phase]);
                    wrap = (m_win == ERR_WIN - 1);
                    m_win = wrap ? 0 : m_win + 1;
                    if (err) begin
                        m_werr = (wrap ? 0 : m_werr) + 1;
                        if (m_werr == ERR_THR) begin
                            m_state = 0; m_match = 0; m_fill.delete();
                        end
                    end else if (wrap) begin
                        m_werr = 0;
                    end
                end
            endcase
        end
        m_pulse = err;
        if (clr_cnt) begin
            m_err = 0;
            m_bc  = 0;
        end else begin
            if (err && m_err < ERR_MAX) m_err++;
            if (lock_bit && m_bc < BC_MAX) m_bc++;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 64'(state), 64'(m_state));
            check("locked", 64'(locked), 64'(m_state == 2));
            check("err_pulse", 64'(err_pulse), 64'(m_pulse));
            check("err_cnt", 64'(err_cnt), 64'(m_err));
`ifdef CDR_PRBS_BITCNT_EN
            check("bit_cnt", 64'(bit_cnt), 64'(m_bc));
`endif
        end
    end

    task automatic send(input bit b, input bit v, input bit c, input bit r);
        @(negedge clk);
        bit_in = b; bit_valid = v; clr_cnt = c; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic clean(input int n);
        repeat (n) send(tx_next(), 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bit noise;
        build_seq();
        tx_ph = $urandom_range(0, 126);

        send(1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        check("rst_state", 64'(state), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_err_pulse", 64'(err_pulse), 64'd0);

        // Clean lock: VERIFY after 7 bits, LOCKED after 23.
        clean(7);
        check("fill7_state", 64'(state), 64'd1);
        clean(15);
        check("bit22_state", 64'(state), 64'd1);
        check("bit22_locked", 64'(locked), 64'd0);
        clean(1);
        check("bit23_state", 64'(state), 64'd2);
        check("bit23_locked", 64'(locked), 64'd1);
        clean(40);
        check("clean_err_cnt", 64'(err_cnt), 64'd0);

        // Single error while locked.
        send(~tx_next(), 1'b1, 1'b0, 1'b0);
        check("single_pulse", 64'(err_pulse), 64'd1);
        check("single_err_cnt", 64'(err_cnt), 64'd1);
        check("single_locked", 64'(locked), 64'd1);
        clean(10);
        check("single_pulse_gone", 64'(err_pulse), 64'd0);
        check("single_err_hold", 64'(err_cnt), 64'd1);

        // Loss of lock: 8 errors at the start of one window.
        send(tx_next(), 1'b1, 1'b1, 1'b0);
        check("clr_err_cnt", 64'(err_cnt), 64'd0);
        for (int i = 0; i < ERR_WIN && m_win != 0; i++) clean(1);
        for (int e = 0; e < ERR_THR; e++) begin
            send(~tx_next(), 1'b1, 1'b0, 1'b0);
            if (e < ERR_THR - 1) begin
                check("lol_still_locked", 64'(locked), 64'd1);
                clean(1);
            end
        end
        check("lol_state", 64'(state), 64'd0);
        check("lol_err_cnt", 64'(err_cnt), 64'd8);
        clean(22);
        check("relock22_state", 64'(state), 64'd1);
        clean(1);
        check("relock23_state", 64'(state), 64'd2);

        // All-zero input never leaves SEARCH.
        send(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (100) send(1'b0, 1'b1, 1'b0, 1'b0);
        check("zero_state", 64'(state), 64'd0);
        check("zero_locked", 64'(locked), 64'd0);
        check("zero_err_cnt", 64'(err_cnt), 64'd0);

        // Sparse valid: one strobe every third cycle.
        send(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 23; i++) begin
            send(1'b0, 1'b0, 1'b0, 1'b0);
            send(1'b1, 1'b0, 1'b0, 1'b0);
            send(tx_next(), 1'b1, 1'b0, 1'b0);
            if (i == 21) check("sparse22_state", 64'(state), 64'd1);
        end
        check("sparse_lock_state", 64'(state), 64'd2);
        check("sparse_locked", 64'(locked), 64'd1);
        send(1'b0, 1'b0, 1'b0, 1'b0);
        send(~tx_next(), 1'b1, 1'b1, 1'b0);
        check("collide_pulse", 64'(err_pulse), 64'd1);
        check("collide_err_cnt", 64'(err_cnt), 64'd0);
        send(1'b0, 1'b0, 1'b0, 1'b0);
        check("collide_pulse_gone", 64'(err_pulse), 64'd0);

        // Saturation: 20 errors, 16 bits apart, never reaching the window threshold.
        for (int e = 0; e < 20; e++) begin
            clean(15);
            send(~tx_next(), 1'b1, 1'b0, 1'b0);
        end
        check("sat_err_cnt", 64'(err_cnt), 64'd15);
        check("sat_locked", 64'(locked), 64'd1);
        send(~tx_next(), 1'b1, 1'b0, 1'b1);
        check("rst_locked_state", 64'(state), 64'd0);
        check("rst_locked_locked", 64'(locked), 64'd0);
        check("rst_locked_pulse", 64'(err_pulse), 64'd0);
        check("rst_locked_err_cnt", 64'(err_cnt), 64'd0);

        // Randomised traffic against the model.
        noise = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            bit r, cl, v, b;
            r  = ($urandom_range(0, 999) < 3);
            cl = ($urandom_range(0, 99) == 0);
            v  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) noise = ~noise;
            if (!v || noise) b = 1'($urandom_range(0, 1));
            else b = tx_next() ^ ($urandom_range(0, 59) == 0);
            send(b, v, cl, r);
        end

        send(1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cdr_prbs_checker.md
# cdr_prbs_checker

PRBS-7 checker downstream of the baud-rate CDR. It consumes the recovered bit stream and its per-bit valid strobe, self-synchronises a local PRBS-7 generator to the stream, and declares lock. Once locked it counts bit errors, so the recovered data can be measured for BER on silicon. It sits between the CDR's recovered-data output and the project's status/output mux.

## Interface
Parameters:
- `LOCK_CNT`, default 16: consecutive matching bits needed in VERIFY before declaring lock (range 1..255).
- `ERR_WIN`, default 64: length of the LOCKED-state error window, counted in valid bits (range 2..1024).
- `ERR_THR`, default 8: errors within one window that force loss of lock (range 1..`ERR_WIN`).
- `ECW`, default 16: width of the error counter.

Ports:
- `clk`  in  1  single clock; every register is clocked on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bit_in`  in  1  recovered data bit from the CDR.
- `bit_valid`  in  1  `bit_in` is a new bit this cycle (one-cycle strobe).
- `clr_cnt`  in  1  synchronous clear of the counters.
- `locked`  out  1  checker is in LOCKED.
- `state`  out  2  current state: SEARCH=0, VERIFY=1, LOCKED=2.
- `err_pulse`  out  1  one-cycle pulse for each mismatching bit while LOCKED.
- `err_cnt`  out  ECW  saturating count of bit errors seen while LOCKED.

## Operation
- Polynomial is x^7+x^6+1. The 7-bit shift register `sr` shifts left with the new bit inserted at bit 0. The predicted next bit is `sr[6]^sr[5]`.
- Cycles with `bit_valid` low change nothing except the `clr_cnt` and `rst` effects.
- **SEARCH**
  - Each valid bit is shifted into `sr` and increments a fill counter.
  - On the 7th fill: if the resulting `sr` is nonzero, go to VERIFY. If it is all zero (the PRBS lock-up state), restart filling with the fill counter at 0 and stay in SEARCH.
- **VERIFY**
  - Each valid bit is compared against the prediction, and `sr` shifts in the predicted bit.
  - On a match, the match counter increments. When it reaches `LOCK_CNT`, go to LOCKED and clear the window counters.
  - On a mismatch, go to SEARCH with the fill and match counters cleared.
- **LOCKED**
  - Compare and shift work as in VERIFY.
  - Each valid bit increments the window counter, which wraps from `ERR_WIN`-1 to 0.
  - Each mismatch increments the window error counter, pulses `err_pulse`, and increments `err_cnt`.
  - If a mismatch brings the window error count to `ERR_THR`, go to SEARCH. That final error is still counted and pulsed.
  - When the window counter wraps, the window error counter resets to 0. If the wrapping bit is itself an error, the new window's error count is 1.
- **Counters**
  - `err_cnt` saturates at all-ones and never wraps.
  - When `clr_cnt` and an error occur on the same edge, clear wins and `err_cnt` becomes 0. `err_pulse` still fires.
  - `clr_cnt` does not affect `state`, `sr`, or the lock and window logic.
- `rst` returns every register to its reset value on the next edge, even mid-fill or while LOCKED.

## Timing
- All outputs are registered.
- Reset values: `state`=0 (SEARCH), `locked`=0, `err_pulse`=0, `err_cnt`=0, `sr`=0, all internal counters 0.
- Latency from the valid bit to the output is one edge. For the bit that completes lock, `locked` is high from the following cycle.
- `err_pulse` is high for exactly the cycle after the edge that sampled the erroneous bit. `err_cnt` updates on that same edge.
- Back-to-back `bit_valid` on every cycle is supported with no stall.
- Minimum time to lock from reset with a clean stream is 7 + `LOCK_CNT` valid bits.

## Configuration
- The macro is `CDR_PRBS_BITCNT_EN`.
- **Defined:** adds output port `bit_cnt` (out, 32 bits).
  - It counts valid bits received while LOCKED and saturates at 0xFFFFFFFF.
  - It is cleared by `rst` and `clr_cnt`, with the same clear-wins rule as `err_cnt`.
  - It gives the BER denominator.
- **Undefined:** the port and its counter are absent, and all other behaviour is identical.

## Test plan
- **Clean lock:** reset, then a continuous PRBS-7 stream with `bit_valid`=1 on every cycle.
  - `state` goes 0→1 after 7 bits and 1→2 after 16 more; `locked` is high from the cycle after bit 23.
  - `err_cnt` stays 0.
- **Single error while locked:** after lock, invert one bit.
  - Exactly one `err_pulse`; `err_cnt`=1; `locked` stays high.
- **Loss of lock:** after lock, invert 8 bits inside one 64-bit window.
  - `state` returns to 0 after the 8th error; `err_cnt`=8.
  - A clean stream afterwards relocks after 23 valid bits.
- **All-zero input:** 100 zero bits.
  - `state` stays 0; `locked` stays 0; `err_cnt` stays 0.
- **Sparse valid and collision:** `bit_valid` asserted on every 3rd cycle with a clean stream.
  - Lock occurs after 23 valid strobes.
  - Then `clr_cnt` asserted on the same edge as an injected error: `err_cnt`=0 and `err_pulse`=1.
- **Saturation and reset:** with `ECW`=4, inject 20 errors spread so the window threshold is never reached.
  - `err_cnt` holds at 15.
  - Asserting `rst` while LOCKED returns every output to 0 on the next edge.
